order_packetizer: RTL and testbench

Sits directly downstream of the custom IP core's 32-bit master AXI-Stream output, and takes each processed price word from it. Each word is compared against buy/sell thresholds. A word that triggers a trade becomes a 3-beat order message on an AXI-Stream master with tlast; all other words are dropped. A small input FIFO decouples the core from order-link backpressure.

---
 rtl/order_packetizer.sv | 179 +++++++++++++++++
 tb/tb_order_packetizer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_packetizer.sv
// order_packetizer: turns price words from the upstream core into 3-beat
// AXI-Stream order messages (header, price, quantity) when a price crosses
// the buy or sell threshold. A small FIFO absorbs order-link backpressure.
module order_packetizer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        enable,
  input  logic [31:0] buy_threshold,
  input  logic [31:0] sell_threshold,
  input  logic [15:0] order_qty,
  output logic [15:0] order_count,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PRICE = 2'd2,
    QTY   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifoFull, fifoEmpty, push, pop;
  logic [31:0]      fifoHead;

  // FSM and output registers
  state_t      state_q, state_d;
  logic [31:0] price_q, price_d;
  logic [15:0] qty_q, qty_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] orderCnt_q, orderCnt_d;
  logic [15:0] dropCnt_q, dropCnt_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        isBuy, isSell;

  assign fifoFull      = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty     = (count_q == '0);
  assign fifoHead      = mem_q[rdPtr_q];
  assign s_axis_tready = !fifoFull;
  // A full FIFO refuses the word even when a pop frees a slot this cycle.
  assign push          = s_axis_tvalid && !fifoFull;

  // BUY takes priority when both thresholds are satisfied.
  assign isBuy  = enable && (fifoHead <= buy_threshold);
  assign isSell = enable && !isBuy && (fifoHead >= sell_threshold);

  // Storage array has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= s_axis_tdata;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic: classify on pop, then walk header/price/qty beats.
  always_comb begin
    state_d    = state_q;
    price_d    = price_q;
    qty_d      = qty_q;
    seq_d      = seq_q;
    orderCnt_d = orderCnt_q;
    dropCnt_d  = dropCnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          price_d = fifoHead;
          qty_d   = order_qty;
          if (isBuy || isSell) begin
            state_d  = HDR;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            tdata_d  = {MAGIC, 7'b0, isSell, seq_q};
          end else if (dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'd1;
          end
        end
      end
      HDR: begin
        if (m_axis_tready) begin
          state_d = PRICE;
          tdata_d = price_q;
        end
      end
      PRICE: begin
        if (m_axis_tready) begin
          state_d = QTY;
          tdata_d = {16'h0, qty_q};
          tlast_d = 1'b1;
        end
      end
      QTY: begin
        if (m_axis_tready) begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = '0;
          seq_d    = seq_q + 16'd1;
          if (orderCnt_q != 16'hFFFF) begin
            orderCnt_d = orderCnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched order fields, counters and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      price_q    <= '0;
      qty_q      <= '0;
      seq_q      <= '0;
      orderCnt_q <= '0;
      dropCnt_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      price_q    <= price_d;
      qty_q      <= qty_d;
      seq_q      <= seq_d;
      orderCnt_q <= orderCnt_d;
      dropCnt_q  <= dropCnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign order_count   = orderCnt_q;
  assign drop_count    = dropCnt_q;
  assign busy          = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_order_packetizer.sv
// tb_order_packetizer: directed scenarios for order_packetizer with
// hand-computed expected beats and counter values.
module tb_order_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        enable;
  logic [31:0] buyTh;
  logic [31:0] sellTh;
  logic [15:0] orderQty;
  logic [15:0] orderCount;
  logic [15:0] dropCount;
  logic        busy;

  int errors = 0;
  int checks = 0;

  order_packetizer #(.FIFO_DEPTH(4), .MAGIC(8'hA5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .enable         (enable),
    .buy_threshold  (buyTh),
    .sell_threshold (sellTh),
    .order_qty      (orderQty),
    .order_count    (orderCount),
    .drop_count     (dropCount),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (drive/sample point).
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one input word until accepted, bounded by a cycle budget.
  task automatic sendWord(input logic [31:0] w, output bit ok);
    ok       = 1'b0;
    s_tdata  = w;
    s_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (s_tready) begin
        stepCycle();
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    s_tvalid = 1'b0;
  endtask

  // Wait for the next output handshake and return its beat, bounded.
  task automatic getBeat(output logic [31:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_tvalid && m_tready) begin
        d = m_tdata;
        l = m_tlast;
        stepCycle();
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got valid=%b last=%b data=%h want 0 0 00000000", m_tvalid, m_tlast, m_tdata);
    end
    checks++;
    if (orderCount !== 16'h0 || dropCount !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_counters got orders=%h drops=%h busy=%b want 0 0 0", orderCount, dropCount, busy);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tready got %b want 1", s_tready);
    end
  endtask

  task automatic test_buy();
    logic [31:0] expD [3];
    logic [31:0] d;
    logic        l;
    bit          ok;
    expD = '{32'hA5000000, 32'h00000800, 32'h00000064};
    buyTh    = 32'h1000;
    sellTh   = 32'h2000;
    orderQty = 16'h0064;
    enable   = 1'b1;
    m_tready = 1'b1;
    sendWord(32'h00000800, ok);
    checks++;
    if (!ok || m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buy_accept got ok=%0d valid=%b want ok=1 valid=0", ok, m_tvalid);
    end
    stepCycle();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5000000) begin
      errors++;
      $display("[TB] FAIL buy_latency got valid=%b data=%h want 1 A5000000", m_tvalid, m_tdata);
    end
    for (int i = 0; i < 3; i++) begin
      getBeat(d, l, ok);
      checks++;
      if (!ok || d !== expD[i] || l !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL buy_beat%0d got ok=%0d data=%h last=%b want %h %b", i, ok, d, l, expD[i], (i == 2));
      end
    end
    checks++;
    if (orderCount !== 16'd1 || m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL buy_count got orders=%0d valid=%b want 1 0", orderCount, m_tvalid);
    end
  endtask

  task automatic test_sell_drop();
    logic [31:0] expD [3];
    logic [31:0] d;
    logic        l;
    bit          ok1, ok2, ok;
    expD = '{32'hA5010001, 32'h00003000, 32'h00000064};
    sendWord(32'h00003000, ok1);
    sendWord(32'h00001800, ok2);
    checks++;
    if (!ok1 || !ok2) begin
      errors++;
      $display("[TB] FAIL sell_accept got ok=%0d,%0d want 1,1", ok1, ok2);
    end
    for (int i = 0; i < 3; i++) begin
      getBeat(d, l, ok);
      checks++;
      if (!ok || d !== expD[i] || l !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL sell_beat%0d got ok=%0d data=%h last=%b want %h %b", i, ok, d, l, expD[i], (i == 2));
      end
    end
    for (int i = 0; i < 3; i++) stepCycle();
    checks++;
    if (dropCount !== 16'd1 || orderCount !== 16'd2 || m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sell_counts got drops=%0d orders=%0d valid=%b want 1 2 0", dropCount, orderCount, m_tvalid);
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    int          lasts;
    bit          acc;
    bit          ok;
    logic [31:0] d;
    logic        l;
    logic [31:0] want;
    doReset();
    m_tready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (idx < 8) begin
        s_tvalid = 1'b1;
        s_tdata  = 32'h100 + 32'(idx);
      end else begin
        s_tvalid = 1'b0;
      end
      acc = s_tvalid && s_tready;
      stepCycle();
      if (acc) idx++;
    end
    s_tvalid = 1'b0;
    checks++;
    if (idx !== 5 || s_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accepted got accepted=%0d tready=%b want 5 0", idx, s_tready);
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5000000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_header got valid=%b data=%h busy=%b want 1 A5000000 1", m_tvalid, m_tdata, busy);
    end
    for (int i = 0; i < 3; i++) stepCycle();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5000000 || m_tlast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stable got valid=%b data=%h last=%b want 1 A5000000 0", m_tvalid, m_tdata, m_tlast);
    end
    m_tready = 1'b1;
    lasts = 0;
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 3; b++) begin
        case (b)
          0:       want = 32'hA5000000 | 32'(k);
          1:       want = 32'h100 + 32'(k);
          default: want = 32'h00000064;
        endcase
        getBeat(d, l, ok);
        if (l) lasts++;
        checks++;
        if (!ok || d !== want || l !== (b == 2)) begin
          errors++;
          $display("[TB] FAIL bp_order%0d_beat%0d got ok=%0d data=%h last=%b want %h %b", k, b, ok, d, l, want, (b == 2));
        end
      end
    end
    checks++;
    if (lasts !== 5 || busy !== 1'b0 || orderCount !== 16'd5) begin
      errors++;
      $display("[TB] FAIL bp_done got lasts=%0d busy=%b orders=%0d want 5 0 5", lasts, busy, orderCount);
    end
  endtask

  task automatic test_disabled();
    bit sawValid;
    sawValid = 1'b0;
    enable   = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'h10 * 32'(i + 1);
      checks++;
      if (s_tready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dis_tready%0d got %b want 1", i, s_tready);
      end
      if (m_tvalid) sawValid = 1'b1;
      stepCycle();
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_tvalid) sawValid = 1'b1;
      stepCycle();
    end
    checks++;
    if (sawValid !== 1'b0 || dropCount !== 16'd3 || s_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dis_drop got sawValid=%b drops=%0d tready=%b want 0 3 1", sawValid, dropCount, s_tready);
    end
  endtask

  task automatic test_buy_priority();
    logic [31:0] expD [3];
    logic [31:0] d;
    logic        l;
    bit          ok;
    expD = '{32'hA5000005, 32'h00004800, 32'h000000AB};
    enable   = 1'b1;
    buyTh    = 32'h5000;
    sellTh   = 32'h4000;
    orderQty = 16'h00AB;
    m_tready = 1'b0;
    sendWord(32'h00004800, ok);
    stepCycle();
    orderQty = 16'h1234;
    enable   = 1'b0;
    buyTh    = 32'h0;
    m_tready = 1'b1;
    checks++;
    if (!ok || m_tdata[16] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_side got ok=%0d side=%b want 1 0", ok, m_tdata[16]);
    end
    for (int i = 0; i < 3; i++) begin
      getBeat(d, l, ok);
      checks++;
      if (!ok || d !== expD[i] || l !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL prio_beat%0d got ok=%0d data=%h last=%b want %h %b", i, ok, d, l, expD[i], (i == 2));
      end
    end
    enable   = 1'b1;
    buyTh    = 32'h5000;
    orderQty = 16'h0064;
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] expD [3];
    logic [31:0] d;
    logic        l;
    bit          ok;
    expD = '{32'hA5000000, 32'h00000200, 32'h00000064};
    m_tready = 1'b0;
    sendWord(32'h00000100, ok);
    stepCycle();
    m_tready = 1'b1;
    stepCycle();
    m_tready = 1'b0;
    checks++;
    if (!ok || m_tvalid !== 1'b1 || m_tdata !== 32'h00000100) begin
      errors++;
      $display("[TB] FAIL mid_price got ok=%0d valid=%b data=%h want 1 1 00000100", ok, m_tvalid, m_tdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_async got valid=%b data=%h want 0 00000000", m_tvalid, m_tdata);
    end
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checks++;
    if (orderCount !== 16'd0 || dropCount !== 16'd0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_counters got orders=%0d drops=%0d valid=%b want 0 0 0", orderCount, dropCount, m_tvalid);
    end
    m_tready = 1'b1;
    sendWord(32'h00000200, ok);
    for (int i = 0; i < 3; i++) begin
      getBeat(d, l, ok);
      checks++;
      if (!ok || d !== expD[i] || l !== (i == 2)) begin
        errors++;
        $display("[TB] FAIL mid_beat%0d got ok=%0d data=%h last=%b want %h %b", i, ok, d, l, expD[i], (i == 2));
      end
    end
    checks++;
    if (orderCount !== 16'd1) begin
      errors++;
      $display("[TB] FAIL mid_count got %0d want 1", orderCount);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    enable   = 1'b0;
    buyTh    = '0;
    sellTh   = '1;
    orderQty = '0;
    #1;
    test_reset();
    test_buy();
    test_sell_drop();
    test_backpressure();
    test_disabled();
    test_buy_priority();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
